// File: rtl/kamus_l1d_mem.sv
// rtl/kamus_l1d_mem.sv - word-organised L1 data RAM answering the MEM stage
// Zero-sweeps after reset; dropped writes latch a sticky error and the first offending address.
module kamus_l1d_mem #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        l1d_wr_en_i,
  input  logic [31:0] l1d_addr_i,
  input  logic [31:0] l1d_wr_data_i,
  output logic [31:0] l1d_rd_data_o,
  output logic        l1d_ready_o,
  input  logic        err_clr_i,
  output logic        l1d_err_o,
  output logic [31:0] l1d_err_addr_o
);

  localparam int          ADDR_W = $clog2(DEPTH);
  localparam logic [32:0] SPAN   = 33'(DEPTH) << 2;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {INIT, READY} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   init_cnt_q;
  logic                ready_q;
  logic                err_q;
  logic [31:0]         err_addr_q;

  logic [31:0]         mem [DEPTH];

  logic [31:0]         off;
  logic                in_range;
  logic                aligned;
  logic [ADDR_W-1:0]   idx;
  logic                is_ready;
  logic                acc_wr;
  logic                drop_wr;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [31:0]         mem_wdata;

  always_comb begin
    off      = l1d_addr_i - BASE_ADDR;
    in_range = {1'b0, off} < SPAN;
    aligned  = off[1:0] == 2'b00;
    idx      = off[ADDR_W+1:2];
    is_ready = state_q == READY;
    acc_wr   = is_ready && l1d_wr_en_i && in_range && aligned;
    drop_wr  = is_ready && l1d_wr_en_i && !(in_range && aligned);
  end

  // The single RAM write port is shared between the zero sweep and MEM-stage stores.
  always_comb begin
    mem_we    = !is_ready || acc_wr;
    mem_waddr = is_ready ? idx : init_cnt_q;
    mem_wdata = is_ready ? l1d_wr_data_i : 32'h0;
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign l1d_rd_data_o  = (is_ready && in_range) ? mem[idx] : 32'h0;
  assign l1d_ready_o    = ready_q;
  assign l1d_err_o      = err_q;
  assign l1d_err_addr_o = err_addr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= 32'h0;
    end else begin
      case (state_q)
        INIT: begin
          init_cnt_q <= init_cnt_q + ADDR_W'(1);
          if (init_cnt_q == LAST_IDX) begin
            state_q <= READY;
            ready_q <= 1'b1;
          end
        end
        READY: begin
          // A drop on the same edge as a clear re-arms capture with the new address.
          if (drop_wr) begin
            err_q <= 1'b1;
            if (!err_q || err_clr_i) begin
              err_addr_q <= l1d_addr_i;
            end
          end else if (err_clr_i) begin
            err_q <= 1'b0;
          end
        end
        default: begin
          state_q <= INIT;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kamus_l1d_mem.sv
// tb/tb_kamus_l1d_mem.sv - directed self-checking bench for kamus_l1d_mem
// DEPTH=16, BASE_ADDR=0x1000; inputs change 1 time unit after each rising edge.
module tb_kamus_l1d_mem;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err_clr;
  logic        err;
  logic [31:0] err_addr;

  int pass_cnt = 0;
  int total    = 0;

  kamus_l1d_mem #(.DEPTH(16), .BASE_ADDR(32'h0000_1000)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .l1d_wr_en_i    (wr_en),
    .l1d_addr_i     (addr),
    .l1d_wr_data_i  (wdata),
    .l1d_rd_data_o  (rdata),
    .l1d_ready_o    (ready),
    .err_clr_i      (err_clr),
    .l1d_err_o      (err),
    .l1d_err_addr_o (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] a);
    wr_en   = 1'b0;
    err_clr = 1'b0;
    addr    = a;
    wdata   = 32'h0;
  endtask

  // Runs a full sweep from a just-released reset, checking ready rises after exactly 16 edges.
  task automatic sweep(input string tag);
    for (int k = 1; k <= 16; k++) begin
      chk({tag, "_rd0"}, rdata, 32'h0);
      tick();
      chk({tag, "_ready"}, {31'b0, ready}, {31'b0, (k == 16)});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle(32'h1000);
    tick();
    tick();
    chk("rst_ready", {31'b0, ready}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_err_addr", err_addr, 32'h0);
    chk("rst_rd", rdata, 32'h0);

    // First sweep, with a store presented on the third INIT edge.
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      if (k == 3) begin
        wr_en = 1'b1; addr = 32'h1008; wdata = 32'h5;
      end else begin
        idle(32'h1000);
      end
      chk("init_rd0", rdata, 32'h0);
      tick();
      chk("init_ready", {31'b0, ready}, {31'b0, (k == 16)});
    end
    idle(32'h1008);
    #1;
    chk("init_wr_no_err", {31'b0, err}, 32'h0);
    chk("init_wr_dropped", rdata, 32'h0);

    // Accepted store: old value visible in the same cycle, new value next cycle.
    wr_en = 1'b1; addr = 32'h1004; wdata = 32'hDEAD_BEEF;
    #1;
    chk("wr_same_cycle_old", rdata, 32'h0);
    tick();
    idle(32'h1004);
    #1;
    chk("wr_next_cycle_new", rdata, 32'hDEAD_BEEF);

    // Misaligned then out-of-range stores: first address held.
    wr_en = 1'b1; addr = 32'h1006; wdata = 32'h1111_1111;
    tick();
    wr_en = 1'b1; addr = 32'h2000; wdata = 32'h2222_2222;
    tick();
    idle(32'h1006);
    #1;
    chk("drop_err", {31'b0, err}, 32'h1);
    chk("drop_err_addr", err_addr, 32'h1006);
    chk("misaligned_rd_word", rdata, 32'hDEAD_BEEF);
    addr = 32'h2000;
    #1;
    chk("oor_rd_zero", rdata, 32'h0);

    // Clear coinciding with a drop: error wins and the new address is captured.
    wr_en = 1'b1; err_clr = 1'b1; addr = 32'h0FFC; wdata = 32'h3;
    tick();
    idle(32'h1000);
    chk("clr_vs_drop_err", {31'b0, err}, 32'h1);
    chk("clr_vs_drop_addr", err_addr, 32'h0FFC);
    err_clr = 1'b1;
    tick();
    idle(32'h1000);
    chk("clr_alone", {31'b0, err}, 32'h0);

    // Boundaries: one past the last word is dropped, the last word is accepted.
    wr_en = 1'b1; addr = 32'h1040; wdata = 32'h4;
    tick();
    idle(32'h1040);
    chk("past_end_err", {31'b0, err}, 32'h1);
    chk("past_end_addr", err_addr, 32'h1040);
    wr_en = 1'b1; addr = 32'h103C; wdata = 32'h1234_5678;
    tick();
    idle(32'h103C);
    chk("last_word_rd", rdata, 32'h1234_5678);
    chk("last_word_err_addr_held", err_addr, 32'h1040);

    // Reset in READY wipes contents and error state.
    wr_en = 1'b1; addr = 32'h1010; wdata = 32'h7;
    tick();
    idle(32'h1010);
    chk("pre_rst_rd", rdata, 32'h7);
    rst_n = 1'b0;
    #1;
    chk("rst_ready_immediate", {31'b0, ready}, 32'h0);
    chk("rst_err_cleared", {31'b0, err}, 32'h0);
    chk("rst_rd_zero", rdata, 32'h0);
    tick();
    rst_n = 1'b1;
    sweep("resweep");
    chk("post_rst_rd_1010", rdata, 32'h0);
    addr = 32'h1004;
    #1;
    chk("post_rst_rd_1004", rdata, 32'h0);

    // Reset after five INIT edges restarts the full 16-edge sweep.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle(32'h1000);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("mid_init_ready", {31'b0, ready}, 32'h0);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sweep("restart");
    chk("restart_err_addr", err_addr, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
